// File: rtl/key_debouncer_pkg.sv
// Shared key-handling types and constants for the debouncer, single pulser and later key consumers.
package key_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_CHK,
        PRESSED,
        RELEASE_CHK
    } state_e;

    localparam logic KEY_UP   = 1'b1;
    localparam logic KEY_DOWN = 1'b0;

    // A zero-length debounce window still needs one counter bit to exist.
    function automatic int cnt_width(input int cnt_max);
        return (cnt_max < 1) ? 1 : $clog2(cnt_max + 1);
    endfunction

endpackage

// File: rtl/key_debouncer_if.sv
// Key signal bundle between a raw push-button source and the debouncer.
// Pulse signals exist only when KEY_DEBOUNCER_EDGE_OUT_EN is defined.
interface key_debouncer_if;

    logic key_ni;
    logic key_no;
`ifdef KEY_DEBOUNCER_EDGE_OUT_EN
    logic press_o;
    logic release_o;

    modport master (
        output key_ni,
        input  key_no,
        input  press_o,
        input  release_o
    );

    modport slave (
        input  key_ni,
        output key_no,
        output press_o,
        output release_o
    );
`else
    modport master (
        output key_ni,
        input  key_no
    );

    modport slave (
        input  key_ni,
        output key_no
    );
`endif

endinterface

// File: rtl/key_debouncer_sync_ff.sv
// Generic N-flop synchroniser; the whole chain presets to RST_VAL on reset.
module sync_ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            chain_q <= {STAGES{RST_VAL}};
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/key_debouncer.sv
// Push-button front end: synchronises the raw active-low key and filters bounce into a clean level.
// Define KEY_DEBOUNCER_EDGE_OUT_EN to also get one-cycle press/release pulses.
module key_debouncer
    import key_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int SYNC_STAGES = 2
) (
    input logic           clk_i,
    input logic           rst_i,
    key_debouncer_if.slave key_if
);

    localparam int             CNT_MAX  = CLK_FREQ_HZ / 1000 * DEBOUNCE_MS - 1;
    localparam int             CNT_W    = cnt_width(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);

    logic             key_s;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             key_no_q, key_no_d;

    // The FSM only ever sees the synchronised key, never the raw pin.
    sync_ff #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (KEY_UP)
    ) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (key_if.key_ni),
        .q_o   (key_s)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= RELEASED;
            cnt_q    <= '0;
            key_no_q <= KEY_UP;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            key_no_q <= key_no_d;
        end
    end

    // Any return to the old level during a check restarts from the stable state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        key_no_d = key_no_q;
        case (state_q)
            RELEASED: begin
                if (key_s == KEY_DOWN) begin
                    state_d = PRESS_CHK;
                    cnt_d   = '0;
                end
            end
            PRESS_CHK: begin
                if (key_s == KEY_UP) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = PRESSED;
                    key_no_d = KEY_DOWN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (key_s == KEY_UP) begin
                    state_d = RELEASE_CHK;
                    cnt_d   = '0;
                end
            end
            RELEASE_CHK: begin
                if (key_s == KEY_DOWN) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = RELEASED;
                    key_no_d = KEY_UP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    assign key_if.key_no = key_no_q;

`ifdef KEY_DEBOUNCER_EDGE_OUT_EN
    logic press_q, release_q;

    // Pulses are registered alongside key_no so they coincide with its transition.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            press_q   <= key_no_q & ~key_no_d;
            release_q <= ~key_no_q & key_no_d;
        end
    end

    assign key_if.press_o   = press_q;
    assign key_if.release_o = release_q;
`endif

endmodule

// File: tb/tb_key_debouncer.sv
// Directed self-checking bench for key_debouncer (CNT_MAX=4, two sync stages, 7-edge latency).
module tb_key_debouncer;
    import key_pkg::*;

    localparam int CNT_MAX = 4;
    localparam int LATENCY = 7;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    key_debouncer_if kif ();

    key_debouncer #(
        .CLK_FREQ_HZ (1000),
        .DEBOUNCE_MS (5),
        .SYNC_STAGES (2)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .key_if (kif.slave)
    );

    always #5 clk_i = ~clk_i;

    logic press_obs, release_obs;
`ifdef KEY_DEBOUNCER_EDGE_OUT_EN
    assign press_obs   = kif.press_o;
    assign release_obs = kif.release_o;
`else
    assign press_obs   = 1'b0;
    assign release_obs = 1'b0;
`endif

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        kif.key_ni = KEY_UP;
        rst_i = 1'b1;
        #13;
        vectors++;
        if ({kif.key_no, press_obs, release_obs} !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL reset_async: {key_no,press,release}=%b expected 100",
                     {kif.key_no, press_obs, release_obs});
        end
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            vectors++;
            if ({kif.key_no, press_obs, release_obs} !== 3'b100) begin
                miscompares++;
                $display("[TB] FAIL reset_idle cycle %0d: got %b expected 100", i,
                         {kif.key_no, press_obs, release_obs});
            end
        end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 20; i++) begin
            kif.key_ni = (i < 3 || (i >= 4 && i < 7)) ? KEY_DOWN : KEY_UP;
            tick();
            vectors++;
            if ({kif.key_no, press_obs, release_obs} !== 3'b100) begin
                miscompares++;
                $display("[TB] FAIL bounce edge %0d: got %b expected 100", i,
                         {kif.key_no, press_obs, release_obs});
            end
        end
    endtask

    task automatic test_boundary();
        for (int i = 0; i < 15; i++) begin
            kif.key_ni = (i < CNT_MAX + 1) ? KEY_DOWN : KEY_UP;
            tick();
            vectors++;
            if ({kif.key_no, press_obs, release_obs} !== 3'b100) begin
                miscompares++;
                $display("[TB] FAIL boundary_reject edge %0d: got %b expected 100", i,
                         {kif.key_no, press_obs, release_obs});
            end
        end
    endtask

    task automatic test_press();
        logic [2:0] exp;
        kif.key_ni = KEY_DOWN;
        for (int i = 0; i < 12; i++) begin
            tick();
            exp = {(i >= LATENCY) ? 1'b0 : 1'b1, 1'b0, 1'b0};
`ifdef KEY_DEBOUNCER_EDGE_OUT_EN
            exp[1] = (i == LATENCY);
`endif
            vectors++;
            if ({kif.key_no, press_obs, release_obs} !== exp) begin
                miscompares++;
                $display("[TB] FAIL press edge E+%0d: got %b expected %b", i,
                         {kif.key_no, press_obs, release_obs}, exp);
            end
        end
    endtask

    task automatic test_release();
        logic [2:0] exp;
        kif.key_ni = KEY_UP;
        for (int i = 0; i < 12; i++) begin
            tick();
            exp = {(i >= LATENCY) ? 1'b1 : 1'b0, 1'b0, 1'b0};
`ifdef KEY_DEBOUNCER_EDGE_OUT_EN
            exp[0] = (i == LATENCY);
`endif
            vectors++;
            if ({kif.key_no, press_obs, release_obs} !== exp) begin
                miscompares++;
                $display("[TB] FAIL release edge F+%0d: got %b expected %b", i,
                         {kif.key_no, press_obs, release_obs}, exp);
            end
        end
    endtask

    task automatic test_reset_pressed();
        kif.key_ni = KEY_DOWN;
        repeat (10) tick();
        vectors++;
        if (kif.key_no !== KEY_DOWN) begin
            miscompares++;
            $display("[TB] FAIL held_press: key_no=%b expected 0", kif.key_no);
        end
        #3;
        rst_i = 1'b1;
        #1;
        vectors++;
        if ({kif.key_no, press_obs, release_obs} !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL rst_while_pressed: got %b expected 100",
                     {kif.key_no, press_obs, release_obs});
        end
        tick();
        kif.key_ni = KEY_UP;
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            vectors++;
            if ({kif.key_no, press_obs, release_obs} !== 3'b100) begin
                miscompares++;
                $display("[TB] FAIL post_reset_idle edge %0d: got %b expected 100", i,
                         {kif.key_no, press_obs, release_obs});
            end
        end
    endtask

    task automatic test_reset_mid_check();
        logic [2:0] exp;
        kif.key_ni = KEY_DOWN;
        for (int i = 0; i < 5; i++) tick();
        rst_i = 1'b1;
        #1;
        vectors++;
        if ({kif.key_no, press_obs, release_obs} !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL rst_mid_check: got %b expected 100",
                     {kif.key_no, press_obs, release_obs});
        end
        tick();
        vectors++;
        if ({kif.key_no, press_obs, release_obs} !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL rst_held: got %b expected 100",
                     {kif.key_no, press_obs, release_obs});
        end
        rst_i = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            tick();
            exp = {(i >= LATENCY + 1) ? 1'b0 : 1'b1, 1'b0, 1'b0};
`ifdef KEY_DEBOUNCER_EDGE_OUT_EN
            exp[1] = (i == LATENCY + 1);
`endif
            vectors++;
            if ({kif.key_no, press_obs, release_obs} !== exp) begin
                miscompares++;
                $display("[TB] FAIL relatch edge %0d after reset: got %b expected %b", i,
                         {kif.key_no, press_obs, release_obs}, exp);
            end
        end
    endtask

    initial begin
        $display("[TB] key_debouncer directed bench start");
        test_reset();
        test_bounce();
        test_boundary();
        test_press();
        test_release();
        test_reset_pressed();
        test_reset_mid_check();
        kif.key_ni = KEY_UP;
        repeat (12) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
